dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 118 +++++++++++
 tb/tb_dm_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the CPU M-stage and an external
// loader/debug port. The CPU has priority, and a wait counter stops it from starving the external port.
module dm_arbiter #(
   parameter int AW       = 7,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ext_valid,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_ready,
   output logic [DW-1:0] ext_rdata,
   output logic          ext_rvalid,
   output logic [AW-1:0] dm_addr,
   output logic          dm_write,
   output logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] dm_rdata
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_EXT  = 2'd2
   } grant_e;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   grant_e        grant_s;
   logic [3:0]    wait_cnt_r;
   logic          rvalid_r;
   logic [DW-1:0] rdata_r;
   logic          ext_rd_xfer_s;

   // Grant decision: a starved external port overrides the CPU's priority
   always_comb begin
      grant_s = GNT_NONE;
      if (ext_valid && (wait_cnt_r == MAX_WAIT_C)) begin
         grant_s = GNT_EXT;
      end else if (cpu_req) begin
         grant_s = GNT_CPU;
      end else if (ext_valid) begin
         grant_s = GNT_EXT;
      end else begin
         grant_s = GNT_NONE;
      end
   end

   // Memory-side mux; with no grant the CPU fields are presented with write off
   always_comb begin
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_write = 1'b0;
      case (grant_s)
         GNT_CPU: begin
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
            dm_write = cpu_we;
         end
         GNT_EXT: begin
            dm_addr  = ext_addr;
            dm_wdata = ext_wdata;
            dm_write = ext_we;
         end
         default: begin
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
            dm_write = 1'b0;
         end
      endcase
   end

   assign cpu_rdata     = dm_rdata;
   assign cpu_stall     = cpu_req && (grant_s != GNT_CPU);
   assign ext_ready     = (grant_s == GNT_EXT);
   assign ext_rd_xfer_s = ext_valid && ext_ready && !ext_we;
   // A clear in the cycle after a read transfer suppresses the pending pulse
   assign ext_rvalid    = rvalid_r && !clear;
   assign ext_rdata     = rdata_r;

   // Wait counter counts cycles the external port loses to the CPU
   always_ff @(posedge clk) begin
      if (clear) begin
         wait_cnt_r <= 4'd0;
      end else if (ext_valid && (grant_s == GNT_CPU)) begin
         if (wait_cnt_r < MAX_WAIT_C) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
         end else begin
            wait_cnt_r <= MAX_WAIT_C;
         end
      end else begin
         wait_cnt_r <= 4'd0;
      end
   end

   // External read-data capture and one-cycle valid pulse
   always_ff @(posedge clk) begin
      if (clear) begin
         rvalid_r <= 1'b0;
         rdata_r  <= {DW{1'b0}};
      end else if (ext_rd_xfer_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= dm_rdata;
      end else begin
         rvalid_r <= 1'b0;
         rdata_r  <= rdata_r;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized and directed bench for dm_arbiter. A behavioural model predicts each
// cycle's grant and memory traffic, and a scoreboard queue checks the ext read returns.
module tb_dm_arbiter;

   localparam int AW       = 7;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;

   logic          clk = 1'b0;
   logic          clear, cpu_req, cpu_we, ext_valid, ext_we;
   logic [AW-1:0] cpu_addr, ext_addr;
   logic [DW-1:0] cpu_wdata, ext_wdata;
   logic [DW-1:0] cpu_rdata, ext_rdata, dm_wdata, dm_rdata;
   logic          cpu_stall, ext_ready, ext_rvalid, dm_write;
   logic [AW-1:0] dm_addr;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int            losses;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] held;
   bit            pushed_last;
   logic [DW-1:0] exp_q [$];

   dm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .clear(clear),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_ready(ext_ready), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
      .dm_addr(dm_addr), .dm_write(dm_write), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   // Single-port memory: combinational read, write on the rising edge
   assign dm_rdata = mem[dm_addr];
   always @(posedge clk) begin
      if (dm_write === 1'b1) mem[dm_addr] <= dm_wdata;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, check the outputs the model predicts, and advance the model
   task automatic drive_cycle(input logic clr, input logic cr, input logic cw,
                              input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                              input logic ev, input logic ew,
                              input logic [AW-1:0] ea, input logic [DW-1:0] ed);
      bit            g_ext, g_cpu;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic          wr;
      @(negedge clk);
      clear = clr; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      ext_valid = ev; ext_we = ew; ext_addr = ea; ext_wdata = ed;
      if (clr && pushed_last) void'(exp_q.pop_back());
      pushed_last = 0;
      #1;
      // External wins when it has lost MAX_WAIT times in a row or the CPU is idle
      g_ext = ev && ((losses >= MAX_WAIT) || !cr);
      g_cpu = cr && !g_ext;
      a  = g_ext ? ea : ca;
      wd = g_ext ? ed : cd;
      wr = g_ext ? ew : (g_cpu ? cw : 1'b0);
      check("cpu_stall", 64'(cpu_stall), 64'(cr && !g_cpu));
      check("ext_ready", 64'(ext_ready), 64'(g_ext));
      check("dm_write",  64'(dm_write),  64'(wr));
      check("dm_addr",   64'(dm_addr),   64'(a));
      check("dm_wdata",  64'(dm_wdata),  64'(wd));
      check("ext_rdata_hold", 64'(ext_rdata), 64'(held));
      if (g_cpu && !cw) check("cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[ca]));
      // Advance the model to the state after the coming edge
      if (clr) begin
         losses = 0;
         held   = '0;
      end else begin
         losses = (ev && g_cpu) ? ((losses + 1 > MAX_WAIT) ? MAX_WAIT : losses + 1) : 0;
         if (g_ext && !ew) begin
            held = ref_mem[ea];
            exp_q.push_back(ref_mem[ea]);
            pushed_last = 1;
         end
      end
      if (wr) ref_mem[a] = wd;
   endtask

   task automatic idle(input logic clr);
      drive_cycle(clr, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
   endtask

   // Scoreboard monitor: every ext_rvalid pulse must match the oldest expected read
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (ext_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL ext_rvalid_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
               check("ext_rdata_sb", 64'(ext_rdata), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] d;
      clear = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ext_valid = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
      losses = 0; held = '0; pushed_last = 0;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
      repeat (2) @(negedge clk);

      // Reset state
      idle(1'b0);
      check("rst_ext_rvalid", 64'(ext_rvalid), 64'd0);
      check("rst_ext_rdata",  64'(ext_rdata),  64'd0);

      // Preload every word with back-to-back external writes
      for (int i = 0; i < (1 << AW); i++) begin
         d = $urandom;
         drive_cycle(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b1, 7'(i), d);
         check("preload_ready", 64'(ext_ready), 64'd1);
      end

      // CPU store then load of the same address
      drive_cycle(1'b0, 1'b1, 1'b1, 7'h10, 32'hDEADBEEF, 1'b0, 1'b0, 7'd0, 32'd0);
      check("cpu_wr_dm_write", 64'(dm_write), 64'd1);
      check("cpu_wr_stall", 64'(cpu_stall), 64'd0);
      drive_cycle(1'b0, 1'b1, 1'b0, 7'h10, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
      check("cpu_rd_data", 64'(cpu_rdata), 64'hDEADBEEF);
      check("cpu_rd_stall", 64'(cpu_stall), 64'd0);

      // Starvation: both requesting continuously, so EXT wins every fifth cycle
      idle(1'b0);
      for (int i = 0; i < 11; i++) begin
         drive_cycle(1'b0, 1'b1, 1'b0, 7'(i), 32'd0, 1'b1, 1'b1, 7'h40, 32'(i));
         check("starve_ready", 64'(ext_ready), 64'((i % 5) == 4));
      end

      // External read, then the rvalid pulse the next cycle only
      drive_cycle(1'b0, 1'b1, 1'b1, 7'h20, 32'h12345678, 1'b0, 1'b0, 7'd0, 32'd0);
      drive_cycle(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'h20, 32'd0);
      check("ext_rd_ready", 64'(ext_ready), 64'd1);
      idle(1'b0);
      check("ext_rd_rvalid", 64'(ext_rvalid), 64'd1);
      check("ext_rd_data", 64'(ext_rdata), 64'h12345678);
      idle(1'b0);
      check("ext_rd_rvalid_off", 64'(ext_rvalid), 64'd0);

      // Back-to-back external writes, then an immediate CPU readback
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b1, 7'(4 * i), 32'hA000_0000 + 32'(i));
         check("b2b_ready", 64'(ext_ready), 64'd1);
      end
      drive_cycle(1'b0, 1'b1, 1'b0, 7'h08, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
      check("b2b_readback", 64'(cpu_rdata), 64'hA000_0002);

      // Clear right after an external read suppresses the pulse and zeroes the data
      drive_cycle(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'h04, 32'd0);
      idle(1'b1);
      check("clr_rvalid_suppressed", 64'(ext_rvalid), 64'd0);
      idle(1'b0);
      check("clr_rdata_zero", 64'(ext_rdata), 64'd0);
      check("clr_rvalid_after", 64'(ext_rvalid), 64'd0);

      // Randomized traffic on a narrow address window to force reuse
      for (int i = 0; i < 3000; i++) begin
         drive_cycle(1'b0 | (($urandom % 60) == 0),
                     ($urandom % 3) != 0, $urandom % 2, 7'($urandom_range(0, 15)), $urandom,
                     ($urandom % 4) != 0, $urandom % 2, 7'($urandom_range(0, 15)), $urandom);
      end

      repeat (3) idle(1'b0);
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
